// File: rtl/axi_stream2ui_slave.sv
// ---------------------------------------------------------------------------
// axi_stream2ui_slave
//
// Purpose: AXI-Stream slave that buffers incoming beats in a small show-ahead
// FIFO and presents them on a valid/ready "UI" word interface. The
// frame-length checker can be compiled in optionally. It tracks beats per
// frame, forces a frame end on overrun, discards the overrun tail and flags
// length errors.
//
// Build option: define AXIS2UI_FRAME_CHECK_EN to enable the frame-length
// checker. When it is undefined, TLAST passes straight through, o_frame_err
// is tied 0, and o_frame_cnt counts TLAST beats.
//
// Ports:
//   S_AXIS_ACLK       sole clock
//   S_AXIS_ARESETN    asynchronous active-low reset
//   S_AXIS_TVALID/TDATA/TSTRB/TLAST/TREADY  AXI-Stream slave (TSTRB ignored)
//   o_ui_dvld/o_ui_data/o_ui_dlast  head word of FIFO (show-ahead)
//   i_ui_drdy         UI consumer ready; pops on o_ui_dvld && i_ui_drdy
//   o_frame_err       sticky frame-length error
//   i_err_clr         one-cycle pulse, clears o_frame_err (set wins)
//   o_frame_cnt       frames received, wraps at 16 bits
// ---------------------------------------------------------------------------
module axi_stream2ui_slave #(
  parameter int UI_FRAME_SIZE        = 1024,
  parameter int UI_DATA_WIDTH        = 16,
  parameter int C_S_AXIS_TDATA_WIDTH = 32,
  parameter int FIFO_DEPTH           = 8
) (
  input  logic                              S_AXIS_ACLK,
  input  logic                              S_AXIS_ARESETN,
  input  logic                              S_AXIS_TVALID,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   S_AXIS_TDATA,
  input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] S_AXIS_TSTRB,
  input  logic                              S_AXIS_TLAST,
  output logic                              S_AXIS_TREADY,
  output logic                              o_ui_dvld,
  output logic [UI_DATA_WIDTH-1:0]          o_ui_data,
  output logic                              o_ui_dlast,
  input  logic                              i_ui_drdy,
  output logic                              o_frame_err,
  input  logic                              i_err_clr,
  output logic [15:0]                       o_frame_cnt
);

  localparam int ENTRY_W = UI_DATA_WIDTH + 1;
  localparam int AW      = $clog2(FIFO_DEPTH);

  logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]        wr_ptr, rd_ptr;
  logic               empty, full;
  logic               ready_en;
  logic               accept, store, store_last, pop;

  // TSTRB and the upper TDATA bits are intentionally unused.
  logic unused_inputs;
  assign unused_inputs = ^{S_AXIS_TSTRB, S_AXIS_TDATA, i_err_clr};

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign accept = S_AXIS_TVALID && S_AXIS_TREADY;
  assign pop    = !empty && i_ui_drdy;

  // Holds TREADY low during reset and raises it on the first edge after release.
  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    // NOTE: sequential state uses non-blocking assignments so that every
    // flop samples pre-edge values regardless of block ordering.
    if (!S_AXIS_ARESETN) ready_en <= 1'b0;
    else                 ready_en <= 1'b1;
  end

`ifdef AXIS2UI_FRAME_CHECK_EN
  localparam int CNT_W = $clog2(UI_FRAME_SIZE + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(UI_FRAME_SIZE - 1);

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_DROP} state_t;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic             at_limit, err_evt;

  // count is 0 in S_IDLE, so this one compare also covers UI_FRAME_SIZE == 1.
  assign at_limit   = (count == LAST_IDX);
  assign store      = accept && (state != S_DROP);
  assign store_last = S_AXIS_TLAST || at_limit;
  // Early TLAST (TLAST before limit) or missing TLAST (limit without TLAST).
  assign err_evt    = store && (S_AXIS_TLAST != at_limit);

  assign S_AXIS_TREADY = ready_en && ((state == S_DROP) || !full);

  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      state <= S_IDLE;
      count <= '0;
    end else begin
      case (state)
        S_IDLE, S_RECV: begin
          if (store) begin
            if (store_last) begin
              count <= '0;
              state <= S_AXIS_TLAST ? S_IDLE : S_DROP;
            end else begin
              count <= count + CNT_W'(1);
              state <= S_RECV;
            end
          end
        end
        S_DROP: begin
          if (accept && S_AXIS_TLAST) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN)  o_frame_err <= 1'b0;
    else if (err_evt)     o_frame_err <= 1'b1;
    else if (i_err_clr)   o_frame_err <= 1'b0;
  end
`else
  assign store         = accept;
  assign store_last    = S_AXIS_TLAST;
  assign S_AXIS_TREADY = ready_en && !full;
  assign o_frame_err   = 1'b0;
`endif

  // NOTE: the storage array is deliberately not reset; only the pointers
  // are, and the output mux hides stale contents while the FIFO is empty.
  always_ff @(posedge S_AXIS_ACLK) begin
    if (store) mem[wr_ptr[AW-1:0]] <= {store_last, S_AXIS_TDATA[UI_DATA_WIDTH-1:0]};
  end

  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      o_frame_cnt <= '0;
    end else begin
      if (store)              wr_ptr      <= wr_ptr + (AW+1)'(1);
      if (pop)                rd_ptr      <= rd_ptr + (AW+1)'(1);
      if (store && store_last) o_frame_cnt <= o_frame_cnt + 16'd1;
    end
  end

  // Show-ahead head word; forced to zero while empty (including reset).
  assign o_ui_dvld               = !empty;
  assign {o_ui_dlast, o_ui_data} = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: doc/axi_stream2ui_slave.md
AXI_STREAM2UI_SLAVE -- requirements
Module: axi_stream2ui_slave

Interface
REQ-001 SHALL have parameter UI_FRAME_SIZE, default 1024, meaning words per frame.
REQ-002 SHALL have parameter UI_DATA_WIDTH, default 16, meaning UI data width; must be <= C_S_AXIS_TDATA_WIDTH.
REQ-003 SHALL have parameter C_S_AXIS_TDATA_WIDTH, default 32, meaning AXIS data width.
REQ-004 SHALL have parameter FIFO_DEPTH, default 8, meaning buffer entries; must be a power of 2, >= 2.
REQ-005 Ports, one per line (name  direction  width  meaning). The clock domain is single and the reset is asynchronous and active-low.
- S_AXIS_ACLK  in  1  sole clock.
- S_AXIS_ARESETN  in  1  reset, asynchronous, active-low.
- S_AXIS_TVALID  in  1  beat valid.
- S_AXIS_TDATA  in  C_S_AXIS_TDATA_WIDTH  beat data.
- S_AXIS_TSTRB  in  C_S_AXIS_TDATA_WIDTH/8  ignored.
- S_AXIS_TLAST  in  1  frame end.
- S_AXIS_TREADY  out  1  beat accepted when TVALID&&TREADY.
- o_ui_dvld  out  1  UI word valid.
- o_ui_data  out  UI_DATA_WIDTH  TDATA[UI_DATA_WIDTH-1:0] of head word.
- o_ui_dlast  out  1  head word ends frame.
- i_ui_drdy  in  1  UI consumer ready; word transferred when o_ui_dvld&&i_ui_drdy.
- o_frame_err  out  1  sticky frame-length error.
- i_err_clr  in  1  one-cycle pulse, clears o_frame_err.
- o_frame_cnt  out  16  frames received, wraps 0xFFFF->0.

Function
REQ-006 SHALL buffer accepted beats in a FIFO_DEPTH-entry FIFO storing {last, data[UI_DATA_WIDTH-1:0]}; upper TDATA bits discarded.
REQ-007 SHALL drive S_AXIS_TREADY = !full in S_IDLE/S_RECV, and 1 in S_DROP.
REQ-008 SHALL present the FIFO head show-ahead: o_ui_dvld = !empty; a beat accepted at edge N is visible on o_ui_dvld/o_ui_data in the cycle after edge N (latency 1).
REQ-009 SHALL pop on o_ui_dvld&&i_ui_drdy; simultaneous push and pop SHALL leave occupancy unchanged; no push when full, no pop when empty.
REQ-010 SHALL keep o_ui_data/o_ui_dlast stable while o_ui_dvld=1 and i_ui_drdy=0.
REQ-011 SHALL run a receive FSM: S_IDLE (beat count 0), S_RECV (mid-frame), S_DROP (discarding overrun).
REQ-012 S_IDLE: accepted beat without TLAST -> S_RECV, count=1; accepted beat with TLAST -> stays S_IDLE, early-TLAST error unless UI_FRAME_SIZE=1.
REQ-013 S_RECV: each accepted beat increments count; beat with TLAST and count==UI_FRAME_SIZE-1 -> S_IDLE, no error.
REQ-014 S_RECV early TLAST (count<UI_FRAME_SIZE-1): word stored with last=1, o_frame_err set, -> S_IDLE.
REQ-015 S_RECV missing TLAST (count==UI_FRAME_SIZE-1, TLAST=0): word stored with last=1 (forced), o_frame_err set, -> S_DROP.
REQ-016 S_DROP: accepted beats are not stored; beat with TLAST -> S_IDLE.
REQ-017 o_frame_cnt SHALL increment once per stored last=1 word, at the push edge.
REQ-018 o_frame_err SHALL set on REQ-012/014/015 errors; i_err_clr clears it; set and clear in the same cycle -> set wins.

Reset
REQ-019 On S_AXIS_ARESETN=0 (asynchronous): FIFO empty, FSM S_IDLE, count 0, o_frame_cnt 0, o_frame_err 0, o_ui_dvld 0, o_ui_dlast 0, o_ui_data 0, S_AXIS_TREADY 0 while reset asserted, 1 from the first edge after release.
REQ-020 Reset mid-frame SHALL discard buffered words and partial-frame state; the first beat after release starts a new frame.

Configuration
REQ-021 Macro AXIS2UI_FRAME_CHECK_EN defined: REQ-012..016 and REQ-018 behaviour as stated.
REQ-022 AXIS2UI_FRAME_CHECK_EN undefined: no length check, no S_DROP, last = TLAST, o_frame_err tied 0, o_frame_cnt still counts TLAST beats.

Verification
REQ-023 UI_FRAME_SIZE=4, TVALID=1 always, i_ui_drdy=1, beats 0x1..0x4 with TLAST on 4th -> o_ui_data 1,2,3,4, o_ui_dlast on 4, o_frame_cnt=1, o_frame_err=0.
REQ-024 i_ui_drdy=0, 10 beats offered, FIFO_DEPTH=8 -> TREADY drops after 8 accepted; drdy=1 -> all 10 delivered in order, none lost.
REQ-025 UI_FRAME_SIZE=4, TLAST on 2nd beat -> o_ui_dlast on word 2, o_frame_err=1, next beat starts new frame.
REQ-026 UI_FRAME_SIZE=4, 6 beats, TLAST on 6th -> words 1..4 delivered, dlast forced on 4, beats 5-6 dropped, o_frame_err=1; i_err_clr -> 0.
REQ-027 Reset asserted after 2 beats of a frame -> outputs zero asynchronously; after release, 4-beat frame delivered cleanly, o_frame_cnt=1.
REQ-028 AXIS2UI_FRAME_CHECK_EN undefined, 6-beat frame with TLAST on 6th -> all 6 delivered, dlast on 6, o_frame_err=0.
